// File: rtl/oled_seq_pkg.sv
// oled_seq_pkg: FSM encoding, command ROM entry layout and script indices for oled_seq_ctrl
package oled_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, NEXT, FIN} state_t;
  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       last;
  } rom_entry_t;
  localparam int INIT      = 0;
  localparam int BLACK     = 1;
  localparam int WHITE     = 2;
  localparam int INTERLACE = 3;
endpackage

// File: rtl/oled_seq_ctrl_rom.sv
// oled_cmd_rom: per-script command table with registered output, indexed by script and step
module oled_cmd_rom
  import oled_seq_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_STEPS = 32,
  localparam int IW = $clog2(NUM_REQ),
  localparam int SW = $clog2(MAX_STEPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [IW-1:0] id,
  input  logic [SW-1:0] step,
  output rom_entry_t    entry
);
  rom_entry_t e;
  int s, t;
  always_comb begin
    s = int'(id);
    t = int'(step);
    e = {8'h00, 8'hE3, 1'b1};
    case (s)
      INIT:      e = t == 0 ? {8'h00, 8'hAE, 1'b0} : t == 1 ? {8'h00, 8'hA8, 1'b0} : {8'h00, 8'hAF, 1'b1};
      BLACK:     e = t == 0 ? {8'h00, 8'h21, 1'b0} : t == 1 ? {8'h00, 8'h22, 1'b0} :
                     t == 2 ? {8'h40, 8'h00, 1'b0} : {8'h40, 8'h00, 1'b1};
      WHITE:     e = t == 0 ? {8'h00, 8'h21, 1'b0} : t == 1 ? {8'h40, 8'hFF, 1'b0} : {8'h40, 8'hFF, 1'b1};
      INTERLACE: e = t == 0 ? {8'h40, 8'hAA, 1'b0} : {8'h40, 8'h55, 1'b1};
      default:   e = {8'h00, 8'hE3, 1'b1};
    endcase
  end
  // Loaded only on fetch so the bus bytes stay put through ISSUE and WAIT
  always_ff @(posedge clk or posedge reset)
    if (reset) entry <= '0;
    else if (en) entry <= e;
endmodule

// File: rtl/oled_seq_ctrl.sv
// oled_seq_ctrl: prioritised OLED command-script sequencer driving an I2C master; OLED_SEQ_TIMEOUT_EN adds a WAIT timeout
module oled_seq_ctrl
  import oled_seq_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_STEPS   = 32,
  parameter int TIMEOUT_CYC = 4096,
  localparam int IW = $clog2(NUM_REQ),
  localparam int SW = $clog2(MAX_STEPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [7:0]         i2c_reg_addr,
  output logic [7:0]         i2c_reg_data,
  output logic               i2c_write_en,
  input  logic               i2c_done,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      active_id,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeout_err
);
  state_t state, nxt;
  logic [NUM_REQ-1:0] req_s1, req_s2, req_s3, rise, clr;
  logic [SW-1:0] step;
  logic [IW-1:0] gnt_id;
  logic grant, tmo;
  rom_entry_t entry;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("oled_seq_ctrl: parameter out of range");
  end
  oled_cmd_rom #(.NUM_REQ(NUM_REQ), .MAX_STEPS(MAX_STEPS)) u_rom (
    .clk(clk), .reset(reset), .en(state == FETCH), .id(active_id), .step(step), .entry(entry)
  );
  assign grant = state == IDLE && |pending;
  assign clr = grant ? NUM_REQ'(1) << gnt_id : '0;
  always_comb begin
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (pending[i]) gnt_id = IW'(i);
    nxt = state;
    case (state)
      IDLE:    nxt = grant ? FETCH : IDLE;
      FETCH:   nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = i2c_done ? NEXT : tmo ? IDLE : WAIT;
      NEXT:    nxt = (entry.last || step == SW'(MAX_STEPS - 1)) ? FIN : FETCH;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // A new edge wins over the grant clear, so the running channel can queue a rerun
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      req_s1 <= '0;
      req_s2 <= '0;
      req_s3 <= '0;
      rise <= '0;
      pending <= '0;
      step <= '0;
      active_id <= '0;
    end else begin
      req_s1 <= req_in;
      req_s2 <= req_s1;
      req_s3 <= req_s2;
      rise <= req_s2 & ~req_s3;
      pending <= (pending & ~clr) | rise;
      if (grant) begin
        active_id <= gnt_id;
        step <= '0;
      end else if (state == NEXT && nxt == FETCH) step <= step + 1'b1;
    end
`ifdef OLED_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = state == WAIT && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= state == WAIT ? tcnt + 1'b1 : '0;
      if (grant) timeout_err <= 1'b0;
      else if (tmo && !i2c_done) timeout_err <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  assign i2c_reg_addr = entry.addr;
  assign i2c_reg_data = entry.data;
  assign i2c_write_en = state == ISSUE;
  assign busy = state inside {FETCH, ISSUE, WAIT, NEXT};
  assign done = state == FIN;
endmodule

// File: tb/tb_oled_seq_ctrl.sv
// tb_oled_seq_ctrl: directed and randomised script requests checked against a queue-level model; define OLED_SEQ_TIMEOUT_EN to cover the timeout
module tb_oled_seq_ctrl;
  logic clk = 1'b0, reset = 1'b1, i2c_done = 1'b0;
  logic [3:0] req_in = '0;
  logic [7:0] i2c_reg_addr, i2c_reg_data;
  logic i2c_write_en, busy, done, timeout_err;
  logic [1:0] active_id;
  logic [3:0] pending;
  logic [25:0] outs;
  int checks = 0, failures = 0, done_cnt = 0, we_cnt = 0, inj_budget = 0;
  logic [3:0] mp = '0;
  logic [7:0] last_addr = '0, last_data = '0;
  logic [1:0] last_id = '0;
  logic [15:0] tbl [4][4];
  int len [4];
  always #5 clk = ~clk;
  oled_seq_ctrl #(.NUM_REQ(4), .MAX_STEPS(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .i2c_reg_addr(i2c_reg_addr), .i2c_reg_data(i2c_reg_data),
    .i2c_write_en(i2c_write_en), .i2c_done(i2c_done), .busy(busy), .done(done), .active_id(active_id),
    .pending(pending), .timeout_err(timeout_err)
  );
  assign outs = {i2c_reg_addr, i2c_reg_data, i2c_write_en, busy, done, active_id, pending, timeout_err};
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (i2c_write_en) we_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction
  task automatic kick(input logic [3:0] m);
    int c;
    req_in = '0;
    repeat (3) tick();
    req_in = m;
    mp |= m;
    c = 0;
    while (pending == 4'b0 && c < 12) begin tick(); c++; end
    check("pend_latch", pending, mp);
    c = 0;
    while (!i2c_write_en && c < 10) begin tick(); c++; end
    check("latency", c, 2);
  endtask
  // abort_mode: 0 none, 1 reset during WAIT of abort_step, 2 withhold i2c_done
  task automatic serve(input int id, input int inj_step, input int inj_bit, input int abort_step, input int abort_mode);
    int c, d0, b;
    d0 = done_cnt;
    for (int k = 0; k < len[id]; k++) begin
      c = 0;
      while (!i2c_write_en && c < 40) begin tick(); c++; end
      check("we_seen", i2c_write_en, 1);
      if (!i2c_write_en) return;
      check("active_id", active_id, id);
      check("busy_run", busy, 1);
      check("addr", i2c_reg_addr, tbl[id][k][15:8]);
      check("data", i2c_reg_data, tbl[id][k][7:0]);
      check("terr_clr", timeout_err, 0);
      if (k == 0) check("pend_run", pending, mp);
      last_addr = tbl[id][k][15:8];
      last_data = tbl[id][k][7:0];
      last_id = 2'(id);
      tick();
      check("we_pulse", i2c_write_en, 0);
      if (k == abort_step && abort_mode == 1) begin
        req_in = '0;
        #2 reset = 1'b1;
        #1 check("rst_async", outs, 0);
        tick();
        tick();
        check("rst_hold", outs, 0);
        reset = 1'b0;
        mp = '0;
        last_addr = '0;
        last_data = '0;
        last_id = '0;
        repeat (4) tick();
        check("rst_idle", busy, 0);
        check("rst_pend", pending, 0);
        check("rst_nodone", done_cnt, d0);
        return;
      end
      if (k == abort_step && abort_mode == 2) begin
        c = 1;
        while (busy && c < 40) begin tick(); c++; end
        check("tmo_cycles", c, 17);
        check("tmo_err", timeout_err, 1);
        check("tmo_nodone", done_cnt, d0);
        return;
      end
      req_in = '0;
      repeat (3) tick();
      b = inj_step == k ? inj_bit :
          (inj_step == -1 && inj_budget > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (b >= 0) begin
        req_in[b] = 1'b1;
        mp[b] = 1'b1;
        inj_budget--;
      end
      repeat ($urandom_range(5, 8)) tick();
      check("addr_hold", i2c_reg_addr, tbl[id][k][15:8]);
      check("data_hold", i2c_reg_data, tbl[id][k][7:0]);
      i2c_done = 1'b1;
      tick();
      i2c_done = 1'b0;
    end
    c = 0;
    while (!done && c < 5) begin tick(); c++; end
    check("done", done, 1);
    check("busy_fin", busy, 0);
  endtask
  task automatic run_all(input int inj);
    int id;
    while (mp != 4'b0) begin
      id = lowest(mp);
      mp[id] = 1'b0;
      serve(id, inj, 0, -1, 0);
    end
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int d, w;
    tbl[0][0] = 16'h00AE; tbl[0][1] = 16'h00A8; tbl[0][2] = 16'h00AF; tbl[0][3] = 16'h0000;
    tbl[1][0] = 16'h0021; tbl[1][1] = 16'h0022; tbl[1][2] = 16'h4000; tbl[1][3] = 16'h4000;
    tbl[2][0] = 16'h0021; tbl[2][1] = 16'h40FF; tbl[2][2] = 16'h40FF; tbl[2][3] = 16'h0000;
    tbl[3][0] = 16'h40AA; tbl[3][1] = 16'h4055; tbl[3][2] = 16'h0000; tbl[3][3] = 16'h0000;
    len = '{3, 4, 3, 2};
    repeat (3) tick();
    check("rst_state", outs, 0);
    reset = 1'b0;
    tick();
    d = done_cnt;
    w = we_cnt;
    kick(4'b0001);
    mp[0] = 1'b0;
    serve(0, -2, 0, -1, 0);
    tick();
    check("s0_writes", we_cnt - w, 3);
    check("s0_dones", done_cnt - d, 1);
    check("s0_idle", busy, 0);
    kick(4'b0110);
    run_all(-2);
    d = done_cnt;
    kick(4'b0010);
    mp[1] = 1'b0;
    serve(1, 1, 1, -1, 0);
    run_all(-2);
    check("rerun_dones", done_cnt - d, 2);
    tick();
    d = done_cnt;
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    repeat (3) begin
      tick();
      check("stray", {busy, done, i2c_write_en, active_id, i2c_reg_addr, i2c_reg_data},
            {3'b0, last_id, last_addr, last_data});
    end
    check("stray_nodone", done_cnt, d);
    kick(4'b0001);
    mp[0] = 1'b0;
    serve(0, -2, 0, 2, 1);
`ifdef OLED_SEQ_TIMEOUT_EN
    kick(4'b1000);
    mp[3] = 1'b0;
    serve(3, -2, 0, 0, 2);
    kick(4'b0001);
    mp[0] = 1'b0;
    serve(0, -2, 0, -1, 0);
`else
    check("terr_off", timeout_err, 0);
`endif
    inj_budget = 20;
    for (int it = 0; it < 25; it++) begin
      kick(4'($urandom_range(1, 15)));
      run_all(-1);
    end
    tick();
    check("final_idle", {busy, pending}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
